button_event_scheduler: RTL and testbench
=========================================

# button_event_scheduler

Front-end controller for the board's push-buttons and switches. It synchronizes and debounces N raw inputs using one shared sample-tick prescaler. It converts each debounced press (a 0→1 transition) into a pending event. A round-robin arbiter then shares a single valid/ready event port among the N channels, so downstream FSMs consume one button event at a time instead of polling N level signals.

## Interface
Parameters:
- N_BTN, 4: number of input channels (2..16).
- TICK_DIV, 100000: clk cycles per debounce sample tick (≥2).
- STABLE_TICKS, 8: consecutive disagreeing ticks required to change a clean level (≥2).

Ports:
- clk, in, 1: system clock. One clock domain.
- rst_n, in, 1: reset, asynchronous, active-low.
- raw, in, N_BTN: asynchronous raw switch inputs.
- clean, out, N_BTN: debounced levels.
- evt_valid, out, 1: event offered.
- evt_ready, in, 1: consumer accepts the event when evt_valid && evt_ready.
- evt_id, out, clog2(N_BTN): channel index of the offered event.
- overrun, out, N_BTN: sticky flag, set when a press was lost.
- clr_overrun, in, 1: single-cycle pulse that clears all overrun bits.

## Operation
- Synchronizer: each raw bit passes through 2 flops, producing sync[i].
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when the count equals TICK_DIV-1.
- Per-channel debounce, evaluated only on tick cycles:
  - If sync[i]==clean[i], cnt[i]←0.
  - Otherwise, if cnt[i]==STABLE_TICKS-1, then clean[i]←sync[i] and cnt[i]←0.
  - Otherwise, cnt[i]←cnt[i]+1.
  - The rule is symmetric: press and release use the same filter.
  - cnt width is clog2(STABLE_TICKS). It never wraps.
- Press detect:
  - press[i] = clean[i] & ~clean_d[i], where clean_d is clean registered once.
  - press[i] sets pending[i].
  - Releases produce no event.
- Overrun: if press[i] occurs while pending[i]=1 and channel i is not being accepted that cycle, then overrun[i]←1.
  - If clr_overrun arrives in the same cycle as a set, the set wins.
- Arbiter FSM has two states, IDLE and OFFER.
  - IDLE: if pending≠0, select the first set bit searching upward from last_grant+1 mod N_BTN. Latch it into evt_id, then go to OFFER.
  - OFFER: evt_valid=1 and evt_id is held stable. On evt_ready: clear pending[evt_id], set last_grant←evt_id, and go to IDLE.
  - If a new press on evt_id coincides with acceptance, pending[evt_id] stays set and no overrun is flagged.
  - evt_valid is never withdrawn before acceptance.
- Reset (asynchronous):
  - Outputs: clean=0, evt_valid=0, evt_id=0, overrun=0.
  - Internal state: pending=0, cnt=0, prescaler=0, sync/clean_d=0, FSM=IDLE.
  - last_grant=N_BTN-1, so channel 0 has first priority.
  - Reset asserted mid-OFFER drops evt_valid immediately and discards all pending events.

## Timing
- Synchronizer latency: 2 cycles.
- clean changes on the clock edge of the STABLE_TICKS-th consecutive disagreeing tick. Worst-case latency from a stable raw change is 2 + STABLE_TICKS·TICK_DIV cycles.
- pending[i] sets 2 cycles after clean[i] rises (clean_d, then pending).
- evt_valid rises 1 cycle after pending is set, when the FSM is in IDLE.
- Throughput: at most 1 event per 2 cycles (the OFFER→IDLE→OFFER turnaround).
- Every output is registered; none is combinational from an input.

## Structure
- Package button_pkg holds:
  - the arbiter state enum (ST_IDLE, ST_OFFER);
  - a clog2-based width helper for the evt_id and cnt widths.
- Sub-module debounce_channel (2-flop synchronizer, cnt, clean, clean_d, press) is instantiated N_BTN times.
- The prescaler, pending/overrun registers and arbiter live in the top module.

## Test plan
All scenarios use N_BTN=4, TICK_DIV=4, STABLE_TICKS=3.
1. Reset: drive rst_n=0 asynchronously mid-cycle → clean=0000, evt_valid=0, evt_id=0, overrun=0000 without waiting for a clk edge.
2. Single press: hold raw[1]=1 with evt_ready=1 → clean[1]=1 within 14 cycles; exactly one handshake with evt_id=1; release raw[1] → clean[1]=0 within 14 cycles and no event.
3. Bounce rejection: toggle raw[2] every 5 cycles for 60 cycles → clean[2] stays 0, no event; then hold raw[2] high → exactly one event, id=2.
4. Round-robin order:
   - press ch0 alone and accept it (last_grant=0);
   - then press ch0 and ch3 on the same cycle with evt_ready=1 → events id=3 then id=0;
   - repeat → id=3 first again, since last_grant=0 after the second event.
5. Backpressure and overrun:
   - with evt_ready=0, press ch1, release it, then press it again → evt_valid held, evt_id=1 stable, overrun[1]=1;
   - raise evt_ready → exactly one event, then evt_valid=0;
   - pulse clr_overrun → overrun=0000.
6. Reset mid-offer: assert rst_n=0 while evt_valid=1 and pending=0110 → evt_valid=0 immediately; after release, no events issue until new presses occur.

Source files
------------

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event scheduler:
//   - arb_state_e : state encoding of the round-robin event arbiter
//   - width_for() : clog2-based width helper (never narrower than one bit),
//                   used for the event id and debounce counter widths
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    // Number of bits needed to hold the values 0..count-1, minimum one bit.
    function automatic int unsigned width_for(input int unsigned count);
        int unsigned w;
        w = 1;
        if (count > 2) begin
            w = $clog2(count);
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One input channel: two-flop synchronizer, tick-sampled symmetric debounce
// filter and registered press (rising edge of the clean level) detector.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous switch input
//   tick       : one-cycle sample strobe from the shared prescaler
//   clean      : debounced level
//   press      : one-cycle pulse, registered, one cycle after clean rises
// -----------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int STABLE_TICKS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic clean,
    output logic press
);

    localparam int CNT_W = width_for(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             clean_prev_q, clean_prev_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        cnt_d        = cnt_q;
        clean_d      = clean_q;
        clean_prev_d = clean_q;
        press_d      = clean_q & ~clean_prev_q;

        // The counter tracks consecutive ticks on which the synchronized
        // input disagrees with the clean level; any agreeing tick restarts it.
        if (tick) begin
            if (sync2_q == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                clean_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            clean_q      <= 1'b0;
            clean_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            clean_q      <= clean_d;
            clean_prev_q <= clean_prev_d;
            press_q      <= press_d;
        end
    end

    assign clean = clean_q;
    assign press = press_q;

endmodule

// File: rtl/button_event_scheduler.sv
// -----------------------------------------------------------------------------
// button_event_scheduler
// Debounces N_BTN raw inputs with a shared sample-tick prescaler, turns each
// debounced press into a pending event and offers pending events one at a
// time on a valid/ready port using round-robin arbitration.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw         : asynchronous switch inputs
//   clean       : debounced levels
//   evt_valid   : event offered (held until accepted)
//   evt_ready   : consumer accepts when evt_valid && evt_ready
//   evt_id      : channel index of the offered event
//   overrun     : sticky per-channel flag, a press was lost
//   clr_overrun : single-cycle pulse clearing all overrun bits
// -----------------------------------------------------------------------------
module button_event_scheduler
    import button_pkg::*;
#(
    parameter  int N_BTN        = 4,
    parameter  int TICK_DIV     = 100000,
    parameter  int STABLE_TICKS = 8,
    localparam int ID_W         = width_for(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] raw,
    output logic [N_BTN-1:0] clean,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] overrun,
    input  logic             clr_overrun
);

    localparam int PRESC_W = width_for(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic [N_BTN-1:0]   press;
    logic [N_BTN-1:0]   pending_q, pending_d;
    logic [N_BTN-1:0]   overrun_q, overrun_d;
    logic [N_BTN-1:0]   accept_mask;
    logic               accept;

    arb_state_e         state_q;
    logic               evt_valid_q;
    logic [ID_W-1:0]    evt_id_q;
    logic [ID_W-1:0]    last_grant_q;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;

    // Shared sample-tick prescaler.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .tick  (tick),
            .clean (clean[i]),
            .press (press[i])
        );
    end

    // A press landing on the channel being accepted this cycle re-arms the
    // pending bit instead of being counted as lost; setting overrun beats clear.
    always_comb begin
        accept      = evt_valid_q & evt_ready;
        accept_mask = '0;
        if (accept) begin
            accept_mask[evt_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~accept_mask) | press;
        overrun_d = clr_overrun ? '0 : overrun_q;
        overrun_d = overrun_d | (press & pending_q & ~accept_mask);
    end

    // Round-robin search starting just above the last granted channel.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            cand = ID_W'(idx);
            if (!pick_found && pending_q[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Arbiter: the offer is latched on entry to OFFER and held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            last_grant_q <= ID_W'(N_BTN - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        evt_id_q    <= pick_id;
                        evt_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        evt_valid_q  <= 1'b0;
                        last_grant_q <= evt_id_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_button_event_scheduler
// Directed scenarios followed by a randomized phase. A behavioural model of the
// debounce (run-length of disagreeing sample ticks) and of the event stream
// (one owed event per channel, extra presses are lost) runs alongside the DUT.
// -----------------------------------------------------------------------------
module tb_button_event_scheduler;

    localparam int N_BTN        = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] raw = 4'b0000;
    logic       evt_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [3:0] clean;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] overrun;

    int compare_count = 0;
    int fail_count    = 0;

    // Model and monitor state.
    logic       mon_on = 1'b0;
    logic       edge_live = 1'b0;
    logic [3:0] raw_at_edge = 4'b0000;
    logic [3:0] h1 = 4'b0000;
    logic [3:0] h2 = 4'b0000;
    logic [3:0] m_clean = 4'b0000;
    logic [3:0] m_pending = 4'b0000;
    logic [3:0] m_ovr = 4'b0000;
    int         run_len [4];
    int         edge_k = 0;
    int         rise_count = 0;
    int         hs_count = 0;
    int         hs_q [$];
    logic       hold_prev = 1'b0;
    logic [1:0] id_prev = 2'b00;
    logic       rand_mode = 1'b0;
    int         ready_low_run = 0;

    // 100 MHz-style clock, period 10.
    always #5 clk = ~clk;

    button_event_scheduler #(
        .N_BTN        (N_BTN),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (raw),
        .clean       (clean),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    // Single comparison point: counts, and reports any disagreement.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a raw pattern and hold it for a number of cycles; in random mode
    // evt_ready is randomized but never held low for more than two cycles.
    task automatic apply_stimulus(input logic [3:0] value, input int cycles);
        raw = value;
        for (int c = 0; c < cycles; c++) begin
            if (rand_mode) begin
                if (ready_low_run >= 2) evt_ready = 1'b1;
                else evt_ready = 1'($urandom_range(0, 1));
                ready_low_run = evt_ready ? 0 : ready_low_run + 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for a clean level; an expired budget is a failed comparison.
    task automatic wait_clean(input logic [1:0] ch, input logic level, input int budget, input string tag);
        int n;
        n = 0;
        while (clean[ch] !== level && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output(tag, {31'b0, clean[ch]}, {31'b0, level});
    endtask

    task automatic model_reset();
        edge_k    = 0;
        h1        = 4'b0000;
        h2        = 4'b0000;
        m_clean   = 4'b0000;
        m_pending = 4'b0000;
        m_ovr     = 4'b0000;
        hold_prev = 1'b0;
        for (int i = 0; i < 4; i++) run_len[i] = 0;
    endtask

    // Monitor on the falling edge: first advance the model by the rising edge
    // that just happened, then look at the handshake due on the next edge.
    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst_n) begin
                model_reset();
            end else begin
                if (edge_live) begin
                    edge_k++;
                    if ((edge_k % TICK_DIV) == 0) begin
                        for (int i = 0; i < 4; i++) begin
                            automatic logic [1:0] ix = 2'(i);
                            if (h2[ix] != m_clean[ix]) begin
                                run_len[i]++;
                                if (run_len[i] == STABLE_TICKS) begin
                                    m_clean[ix] = h2[ix];
                                    run_len[i]  = 0;
                                    if (h2[ix]) begin
                                        rise_count++;
                                        if (m_pending[ix]) m_ovr[ix] = 1'b1;
                                        else m_pending[ix] = 1'b1;
                                    end
                                end
                            end else begin
                                run_len[i] = 0;
                            end
                        end
                    end
                    h2 = h1;
                    h1 = raw_at_edge;
                    check_output("clean", {28'b0, clean}, {28'b0, m_clean});
                end
                if (hold_prev) begin
                    check_output("id_stable", {30'b0, evt_id}, {30'b0, id_prev});
                    check_output("valid_held", {31'b0, evt_valid}, 32'd1);
                end
                if (evt_valid && evt_ready) begin
                    check_output("evt_owed", {31'b0, m_pending[evt_id]}, 32'd1);
                    m_pending[evt_id] = 1'b0;
                    hs_q.push_back(int'(evt_id));
                    hs_count++;
                end
                hold_prev = evt_valid && !evt_ready;
                id_prev   = evt_id;
            end
            edge_live   = rst_n;
            raw_at_edge = raw;
        end
    end

    initial begin
        logic [3:0] pat;

        // Asynchronous reset mid-cycle, outputs must clear without a clock edge.
        #12;
        rst_n = 1'b0;
        #1;
        check_output("rst_clean", {28'b0, clean}, 32'd0);
        check_output("rst_valid", {31'b0, evt_valid}, 32'd0);
        check_output("rst_id", {30'b0, evt_id}, 32'd0);
        check_output("rst_overrun", {28'b0, overrun}, 32'd0);
        model_reset();
        mon_on = 1'b1;
        apply_stimulus(4'b0000, 3);
        rst_n = 1'b1;
        apply_stimulus(4'b0000, 4);

        // Single press on channel 1, then release.
        $display("[TB] single press");
        evt_ready = 1'b1;
        raw = 4'b0010;
        wait_clean(2'd1, 1'b1, 20, "t2_rise");
        apply_stimulus(4'b0010, 10);
        check_output("t2_count", hs_q.size(), 32'd1);
        if (hs_q.size() > 0) check_output("t2_id", hs_q[0], 32'd1);
        raw = 4'b0000;
        wait_clean(2'd1, 1'b0, 20, "t2_fall");
        apply_stimulus(4'b0000, 10);
        check_output("t2_no_release_evt", hs_q.size(), 32'd1);
        hs_q.delete();

        // Bounce on channel 2 must be rejected, then a solid press is seen once.
        $display("[TB] bounce rejection");
        pat = 4'b0000;
        for (int t = 0; t < 12; t++) begin
            pat[2] = ~pat[2];
            apply_stimulus(pat, 5);
            check_output("t3_bounce_clean", {31'b0, clean[2]}, 32'd0);
        end
        check_output("t3_bounce_noevt", hs_q.size(), 32'd0);
        raw = 4'b0100;
        wait_clean(2'd2, 1'b1, 20, "t3_rise");
        apply_stimulus(4'b0100, 10);
        check_output("t3_count", hs_q.size(), 32'd1);
        if (hs_q.size() > 0) check_output("t3_id", hs_q[0], 32'd2);
        apply_stimulus(4'b0000, 20);
        hs_q.delete();

        // Round-robin ordering.
        $display("[TB] round robin");
        raw = 4'b0001;
        wait_clean(2'd0, 1'b1, 20, "t4_rise0");
        apply_stimulus(4'b0001, 10);
        check_output("t4_first_count", hs_q.size(), 32'd1);
        if (hs_q.size() > 0) check_output("t4_first_id", hs_q[0], 32'd0);
        apply_stimulus(4'b0000, 20);
        for (int rep = 0; rep < 2; rep++) begin
            hs_q.delete();
            raw = 4'b1001;
            wait_clean(2'd3, 1'b1, 20, "t4_rise3");
            apply_stimulus(4'b1001, 12);
            check_output("t4_pair_count", hs_q.size(), 32'd2);
            if (hs_q.size() == 2) begin
                check_output("t4_pair_first", hs_q[0], 32'd3);
                check_output("t4_pair_second", hs_q[1], 32'd0);
            end
            apply_stimulus(4'b0000, 20);
        end
        hs_q.delete();

        // Backpressure: a second press on a still-pending channel is lost.
        $display("[TB] backpressure and overrun");
        evt_ready = 1'b0;
        apply_stimulus(4'b0010, 16);
        apply_stimulus(4'b0000, 16);
        apply_stimulus(4'b0010, 16);
        check_output("t5_valid", {31'b0, evt_valid}, 32'd1);
        check_output("t5_id", {30'b0, evt_id}, 32'd1);
        check_output("t5_overrun", {28'b0, overrun}, 32'b0010);
        check_output("t5_overrun_model", {28'b0, overrun}, {28'b0, m_ovr});
        evt_ready = 1'b1;
        apply_stimulus(4'b0010, 8);
        check_output("t5_count", hs_q.size(), 32'd1);
        if (hs_q.size() > 0) check_output("t5_evt_id", hs_q[0], 32'd1);
        check_output("t5_valid_drop", {31'b0, evt_valid}, 32'd0);
        clr_overrun = 1'b1;
        m_ovr = 4'b0000;
        apply_stimulus(4'b0010, 1);
        clr_overrun = 1'b0;
        check_output("t5_overrun_clr", {28'b0, overrun}, 32'd0);
        apply_stimulus(4'b0000, 20);
        hs_q.delete();

        // Reset during an offer discards everything.
        $display("[TB] reset mid-offer");
        evt_ready = 1'b0;
        raw = 4'b0110;
        wait_clean(2'd1, 1'b1, 20, "t6_rise");
        apply_stimulus(4'b0110, 6);
        check_output("t6_offer", {31'b0, evt_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        raw = 4'b0000;
        #1;
        check_output("t6_valid_drop", {31'b0, evt_valid}, 32'd0);
        check_output("t6_clean_clr", {28'b0, clean}, 32'd0);
        apply_stimulus(4'b0000, 2);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        apply_stimulus(4'b0000, 40);
        check_output("t6_no_events", hs_q.size(), 32'd0);
        check_output("t6_idle", {31'b0, evt_valid}, 32'd0);

        // Randomized phase with glitches and random backpressure.
        $display("[TB] random phase");
        hs_q.delete();
        rise_count = 0;
        hs_count = 0;
        rand_mode = 1'b1;
        ready_low_run = 0;
        for (int r = 0; r < 30; r++) begin
            pat = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                apply_stimulus(pat ^ (4'b0001 << $urandom_range(0, 3)), 2);
            end
            apply_stimulus(pat, $urandom_range(14, 24));
        end
        rand_mode = 1'b0;
        evt_ready = 1'b1;
        apply_stimulus(4'b0000, 40);
        check_output("rand_drained", {28'b0, m_pending}, 32'd0);
        check_output("rand_evt_total", hs_count, rise_count);
        check_output("rand_overrun", {28'b0, overrun}, {28'b0, m_ovr});
        check_output("rand_idle", {31'b0, evt_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
